// File: rtl/bcd_pkg.sv
// Shared BCD types and constants for the counter and the display multiplexer.
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam int N_DIGITS = 4;
endpackage

// File: rtl/digito_bcd.sv
// One decimal digit, counting modulo 10.
// The co/bo outputs are combinational so that a carry or borrow ripples through the whole chain in one cycle.
module digito_bcd
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  input  logic       dec,
  output bcd_digit_t q,
  output logic       co,
  output logic       bo
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == BCD_MAX) ? '0 : q + 4'd1;
    end else if (dec) begin
      q <= (q == '0) ? BCD_MAX : q - 4'd1;
    end
  end

  assign co = inc & (q == BCD_MAX);
  assign bo = dec & (q == '0);

endmodule

// File: rtl/contador_bcd4.sv
// Four-digit BCD up/down counter stepped by rising edges of debounced button levels,
// with optional wrap or saturation at 9999/0000 and single-cycle step/wrap pulses.
module contador_bcd4
  import bcd_pkg::*;
#(
  parameter bit WRAP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sen_up,
  input  logic        sen_down,
  input  logic        clear,
  output logic [15:0] bcd,
  output logic        wrap_up,
  output logic        wrap_dn,
  output logic        step
);

  logic up_q, dn_q;
  logic up_ev, dn_ev;
  logic is_max, is_zero;
  logic do_inc, do_dec;
  logic [N_DIGITS-1:0] inc_c, dec_c, co, bo;
  bcd_digit_t          q_d [N_DIGITS];

  // Previous samples always follow the live inputs, so a level held through reset or clear yields no event.
  always_ff @(posedge clk) begin
    up_q <= sen_up;
    dn_q <= sen_down;
  end

  assign up_ev   = sen_up & ~up_q;
  assign dn_ev   = sen_down & ~dn_q;
  assign is_max  = (bcd == {N_DIGITS{BCD_MAX}});
  assign is_zero = (bcd == '0);

  // Saturation is decided before the chain is enabled, so a blocked step never touches any digit.
  assign do_inc = ~clear & up_ev & ~dn_ev & (WRAP | ~is_max);
  assign do_dec = ~clear & dn_ev & ~up_ev & (WRAP | ~is_zero);

  assign inc_c[0] = do_inc;
  assign dec_c[0] = do_dec;

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    if (k > 0) begin : g_chain
      assign inc_c[k] = co[k-1];
      assign dec_c[k] = bo[k-1];
    end
    digito_bcd u_digit (
      .clk   (clk),
      .reset (reset),
      .clr   (clear),
      .inc   (inc_c[k]),
      .dec   (dec_c[k]),
      .q     (q_d[k]),
      .co    (co[k]),
      .bo    (bo[k])
    );
    assign bcd[4*k +: 4] = q_d[k];
  end

  // A carry or borrow out of the top digit is exactly the 9999->0000 or 0000->9999 transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      step    <= 1'b0;
      wrap_up <= 1'b0;
      wrap_dn <= 1'b0;
    end else begin
      step    <= do_inc | do_dec;
      wrap_up <= co[N_DIGITS-1];
      wrap_dn <= bo[N_DIGITS-1];
    end
  end

endmodule

// File: tb/tb_contador_bcd4.sv
// Bench for contador_bcd4: wrapping and saturating instances driven in parallel,
// compared each cycle against an integer-count reference through a scoreboard queue.
module tb_contador_bcd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sen_up = 1'b0;
  logic        sen_down = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] bcd_w, bcd_s;
  logic        wu_w, wd_w, st_w, wu_s, wd_s, st_s;

  always #5 clk = ~clk;

  contador_bcd4 #(.WRAP(1'b1)) dut_w (
    .clk(clk), .reset(reset), .sen_up(sen_up), .sen_down(sen_down), .clear(clear),
    .bcd(bcd_w), .wrap_up(wu_w), .wrap_dn(wd_w), .step(st_w)
  );

  contador_bcd4 #(.WRAP(1'b0)) dut_s (
    .clk(clk), .reset(reset), .sen_up(sen_up), .sen_down(sen_down), .clear(clear),
    .bcd(bcd_s), .wrap_up(wu_s), .wrap_dn(wd_s), .step(st_s)
  );

  typedef struct {
    logic [15:0] bcd;
    logic        st;
    logic        wu;
    logic        wd;
  } exp_t;

  exp_t exp_w[$];
  exp_t exp_s[$];
  int   checks = 0;
  int   failures = 0;

  int cnt_w = 0, cnt_s = 0;
  bit prev_up = 1'b0, prev_dn = 1'b0;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // Reference behaviour on a plain integer count 0..9999.
  function automatic exp_t model(input bit wrap, inout int cnt, input bit r, input bit c,
                                 input bit ue, input bit de);
    exp_t e;
    e.st = 1'b0; e.wu = 1'b0; e.wd = 1'b0;
    if (r || c) begin
      cnt = 0;
    end else if (ue && !de) begin
      if (cnt < 9999) begin cnt = cnt + 1; e.st = 1'b1; end
      else if (wrap)  begin cnt = 0; e.st = 1'b1; e.wu = 1'b1; end
    end else if (de && !ue) begin
      if (cnt > 0)    begin cnt = cnt - 1; e.st = 1'b1; end
      else if (wrap)  begin cnt = 9999; e.st = 1'b1; e.wd = 1'b1; end
    end
    e.bcd = to_bcd(cnt);
    return e;
  endfunction

  task automatic drive(input bit r, input bit c, input bit u, input bit d);
    bit ue, de;
    @(negedge clk);
    reset = r; clear = c; sen_up = u; sen_down = d;
    ue = u & ~prev_up;
    de = d & ~prev_dn;
    exp_w.push_back(model(1'b1, cnt_w, r, c, ue, de));
    exp_s.push_back(model(1'b0, cnt_s, r, c, ue, de));
    prev_up = u;
    prev_dn = d;
  endtask

  task automatic press_up(input int hi, input int lo);
    for (int i = 0; i < hi; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < lo; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_dn(input int hi, input int lo);
    for (int i = 0; i < hi; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < lo; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: the DUT presents a registered output every cycle; check it against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_w.size() > 0 && exp_s.size() > 0) begin
        e = exp_w.pop_front();
        chk("bcd_wrap",  bcd_w, e.bcd);
        chk("step_wrap", 16'(st_w), 16'(e.st));
        chk("wup_wrap",  16'(wu_w), 16'(e.wu));
        chk("wdn_wrap",  16'(wd_w), 16'(e.wd));
        e = exp_s.pop_front();
        chk("bcd_sat",  bcd_s, e.bcd);
        chk("step_sat", 16'(st_s), 16'(e.st));
        chk("wup_sat",  16'(wu_s), 16'(e.wu));
        chk("wdn_sat",  16'(wd_s), 16'(e.wd));
      end
    end
  end

  initial begin
    int budget;
    // Reset with the up button held, then keep holding after release.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Ten slow presses.
    for (int i = 0; i < 10; i++) press_up(3, 3);

    // Random stimulus, including occasional clear/reset and coincident edges.
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // 0999 -> 1000 -> 0999.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 999; i++) press_up(1, 1);
    press_up(1, 1);
    press_dn(1, 1);

    // Walk to 9999, then cross the top in both directions.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9999; i++) press_up(1, 1);
    press_up(1, 2);
    press_dn(1, 2);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    press_dn(1, 2);
    press_up(1, 2);

    // Coincident edges at 0042, then clear together with an up edge.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 42; i++) press_up(1, 1);
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset one cycle after an up edge at 0005, button held throughout.
    for (int i = 0; i < 5; i++) press_up(1, 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    budget = 20;
    while ((exp_w.size() > 0 || exp_s.size() > 0) && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    checks++;
    if (exp_w.size() != 0 || exp_s.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d/%0d expectations left, expected 0", exp_w.size(), exp_s.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/contador_bcd4.md
# contador_bcd4

Four-digit BCD up/down counter (0000–9999) that consumes the debounced push-button levels produced by the debouncer stage. It detects rising edges on the debounced up/down levels and steps the count once per press. It drives the packed BCD value to the display multiplexer and emits single-cycle wrap/step pulses.

## Interface
Parameters:
- `WRAP`, 1: 1 = wrap 9999↔0000; 0 = saturate at 9999 (up) and 0000 (down).

Ports:
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `sen_up` input 1: debounced level, count-up button; rising edge = one increment.
- `sen_down` input 1: debounced level, count-down button; rising edge = one decrement.
- `clear` input 1: synchronous clear of count to 0000; level-sensitive.
- `bcd` output 16: packed count; [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units; each nibble 0–9.
- `wrap_up` output 1: one-cycle pulse on 9999→0000 transition.
- `wrap_dn` output 1: one-cycle pulse on 0000→9999 transition.
- `step` output 1: one-cycle pulse whenever `bcd` changes due to an edge (not on clear/reset).

## Operation
- Edge detection: registers `up_q`, `dn_q` hold the previous sample of `sen_up`, `sen_down`.
  - `up_ev = sen_up & ~up_q`; `dn_ev = sen_down & ~dn_q`.
  - `up_q`/`dn_q` update every cycle, including during `clear`.
- Reset (`reset`=1 at clock edge):
  - `bcd`=16'h0000, `wrap_up`=0, `wrap_dn`=0, `step`=0.
  - `up_q<=sen_up`, `dn_q<=sen_down`. A button held through reset produces no event after reset.
- Priority per cycle, highest first: `reset` > `clear` > event.
  - `clear`=1: `bcd`<=0000; pulses 0; events in that cycle are discarded.
  - `up_ev & dn_ev`: cancel; no change, no pulses.
  - `up_ev` only: increment.
  - `dn_ev` only: decrement.
- Increment: units +1; a digit at 9 becomes 0 and carries into the next digit; ripple through all four digits in one cycle.
  - At 9999 with `WRAP`=1: → 0000, `wrap_up`=1, `step`=1.
  - At 9999 with `WRAP`=0: hold, no pulses.
- Decrement: units −1; a digit at 0 becomes 9 and borrows from the next digit.
  - At 0000 with `WRAP`=1: → 9999, `wrap_dn`=1, `step`=1.
  - At 0000 with `WRAP`=0: hold, no pulses.
- Nibbles never leave 0–9. No binary-to-BCD conversion is used; arithmetic is per-digit modulo 10.
- A held level produces exactly one event. A new event requires the level to fall and rise again, so the minimum event spacing is 2 cycles.

## Timing
- Event latency: `sen_up` goes high before clock edge N, so `up_ev` is true during cycle N. `bcd`, `step` and `wrap_*` are registered and visible after edge N, i.e. 1 cycle.
- `step`, `wrap_up`, `wrap_dn` are high for exactly one cycle. `wrap_*` implies `step`.
- `clear` takes effect at the same edge it is sampled; `bcd` reads 0000 the next cycle.
- Reset mid-operation discards any pending event; edge registers reload from live inputs.
- All outputs are registered; no combinational input-to-output path.

## Structure
- Shared package `bcd_pkg`:
  - `typedef logic [3:0] bcd_digit_t`
  - `localparam bcd_digit_t BCD_MAX = 4'd9`
  - `localparam int N_DIGITS = 4`
  - The display multiplexer reuses the same package.
- Sub-module `digito_bcd`, instantiated 4× in a carry/borrow chain:
  - Inputs: `clk`, `reset`, `clr`, `inc`, `dec`.
  - Outputs: `q` (4-bit), combinational `co` (inc & q==9) and `bo` (dec & q==0).
  - Digit k's `inc` = `co` of digit k−1; units are driven by the top-level event.
- Top level owns edge detection, priority, saturation gating (detect 9999/0000 before enabling the chain) and the pulse registers.

## Test plan
- Reset with `sen_up`=1 held, then release `reset` → `bcd`=0000, no `step` while `sen_up` stays high.
- 10 up presses from 0000, each 3 cycles high / 3 low → `bcd`=0010; 10 `step` pulses, each 1 cycle, each 1 cycle after the rising edge.
- Preload 0999 (via 999 presses), then one up press → `bcd`=1000, `step`=1, `wrap_up`=0. Then one down press → 0999.
- `WRAP`=1: at 9999, up press → 0000 with `wrap_up`+`step` for 1 cycle. Then down press → 9999 with `wrap_dn`. `WRAP`=0: same stimulus → stays 9999 / 0000, no pulses.
- `sen_up` and `sen_down` rise on the same edge at 0042 → stays 0042, no pulses. `clear` coincident with an up edge at 0042 → 0000, no `step`.
- Assert `reset` one cycle after an up edge at 0005 → `bcd`=0000 next cycle, no pulses; the held `sen_up` generates no event after reset.
